// File: rtl/router_1xn.sv
// 1-to-N byte-serial packet router: header {len,dest}, payload, parity word.
// Per-port FIFOs with parity/length/destination error reporting and read-timeout flush.
module router_1xn #(
  parameter int DW      = 8,
  parameter int N       = 3,
  parameter int DEST_W  = 2,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pkt_valid,
  input  logic [DW-1:0]   data_in,
  output logic            busy,
  output logic            err,
  output logic [1:0]      err_cause,
  input  logic [N-1:0]    read_enb,
  output logic [N-1:0]    vld_out,
  output logic [N*DW-1:0] data_out
);

  localparam int LW = DW - DEST_W;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DEST_W:0] NL   = (DEST_W + 1)'(N);
  localparam logic [LW-1:0]   CMAX = '1;

  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD, CHECK, DROP} state_t;

  state_t              state;
  logic [DEST_W-1:0]   dest_q;
  logic [LW-1:0]       len_q;
  logic [LW-1:0]       cnt;
  logic [DW-1:0]       par_q;
  logic [DW-1:0]       hdr_q;
  logic                par_bad;

  logic [DW-1:0]       mem    [N][DEPTH];
  logic [PW-1:0]       wr_ptr [N];
  logic [PW-1:0]       rd_ptr [N];
  logic [TW-1:0]       timer  [N];
  logic [DW-1:0]       dout   [N];

  logic [N-1:0]        empty, full, pop, flush, push;
  logic [DEST_W-1:0]   dest_sel;
  logic                in_range, sel_empty, sel_full, sel_flush;
  logic                accept, push_en;
  logic [DW-1:0]       push_data;

  always_comb begin
    dest_sel  = (state == IDLE) ? data_in[DEST_W-1:0] : dest_q;
    in_range  = ({1'b0, dest_sel} < NL);
    sel_empty = 1'b0;
    sel_full  = 1'b0;
    sel_flush = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      empty[k] = (wr_ptr[k] == rd_ptr[k]);
      full[k]  = (wr_ptr[k][AW] != rd_ptr[k][AW]) && (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
      pop[k]   = read_enb[k] & ~empty[k];
      flush[k] = ~empty[k] & ~read_enb[k] & (timer[k] == TW'(TIMEOUT - 1));
      if (dest_sel == DEST_W'(k)) begin
        sel_empty = empty[k];
        sel_full  = full[k];
        sel_flush = flush[k];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      WAIT_EMPTY: busy = 1'b1;
      LOAD:       busy = sel_full;
      CHECK:      busy = 1'b1;
      default:    busy = 1'b0;
    endcase
    accept = ~busy & (((state == IDLE) & pkt_valid) | (state == LOAD) | (state == DROP));
    case (state)
      IDLE:       push_en = accept & in_range & sel_empty;
      WAIT_EMPTY: push_en = sel_empty;
      LOAD:       push_en = accept & ~sel_flush;
      default:    push_en = 1'b0;
    endcase
    push_data = (state == WAIT_EMPTY) ? hdr_q : data_in;
    for (int unsigned k = 0; k < N; k++)
      push[k] = push_en & (dest_sel == DEST_W'(k));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      dest_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      par_q     <= '0;
      hdr_q     <= '0;
      par_bad   <= 1'b0;
      err       <= 1'b0;
      err_cause <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          hdr_q  <= data_in;
          len_q  <= data_in[DW-1:DEST_W];
          dest_q <= data_in[DEST_W-1:0];
          cnt    <= '0;
          par_q  <= data_in;
          if (!in_range) begin
            err       <= 1'b1;
            err_cause <= 2'b11;
            state     <= DROP;
          end else if (sel_empty) begin
            state <= LOAD;
          end else begin
            state <= WAIT_EMPTY;
          end
        end
        // A flush here only empties the previous packet; the held packet then loads.
        WAIT_EMPTY: if (sel_empty) state <= LOAD;
        LOAD: begin
          if (sel_flush) begin
            state <= (accept & ~pkt_valid) ? IDLE : DROP;
          end else if (accept) begin
            if (pkt_valid) begin
              cnt   <= (cnt == CMAX) ? cnt : cnt + 1'b1;
              par_q <= par_q ^ data_in;
            end else begin
              par_bad <= (par_q != data_in);
              state   <= CHECK;
            end
          end
        end
        CHECK: begin
          state <= IDLE;
          if (!sel_flush) begin
            if (par_bad) begin
              err       <= 1'b1;
              err_cause <= 2'b01;
            end else if (cnt != len_q) begin
              err       <= 1'b1;
              err_cause <= 2'b10;
            end
          end
        end
        DROP: if (accept & ~pkt_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < N; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        timer[k]  <= '0;
        dout[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (flush[k]) begin
          wr_ptr[k] <= '0;
          rd_ptr[k] <= '0;
          timer[k]  <= '0;
          dout[k]   <= '0;
        end else begin
          if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
          if (pop[k]) begin
            rd_ptr[k] <= rd_ptr[k] + 1'b1;
            dout[k]   <= mem[k][rd_ptr[k][AW-1:0]];
          end
          timer[k] <= (empty[k] | read_enb[k]) ? '0 : timer[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N; k++)
      if (push[k]) mem[k][wr_ptr[k][AW-1:0]] <= push_data;
  end

  always_comb begin
    data_out = '0;
    for (int unsigned k = 0; k < N; k++) begin
      vld_out[k]            = ~empty[k];
      data_out[k*DW +: DW]  = dout[k];
    end
  end

endmodule

// File: tb/tb_router_1xn.sv
// Scoreboard bench for router_1xn: sender pushes expected words/error causes,
// a negedge monitor pops and compares on every pop, flush and error pulse.
module tb_router_1xn;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic        busy, err;
  logic [1:0]  err_cause;
  logic [2:0]  read_enb, vld_out;
  logic [23:0] data_out;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [3][$];
  logic [1:0]  err_q [$];
  logic [2:0]  rd_mask;
  int          flush_drop [3];
  bit   [2:0]  flush_seen;
  int          words_acc, stall_cnt;

  router_1xn #(.DW(8), .N(3), .DEST_W(2), .DEPTH(16), .TIMEOUT(30)) dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .busy(busy), .err(err), .err_cause(err_cause),
    .read_enb(read_enb), .vld_out(vld_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Present one word and hold it until an edge with busy low takes it.
  task automatic put(input logic [7:0] w, input logic v);
    bit b;
    data_in   = w;
    pkt_valid = v;
    for (int t = 0; t < 3000; t++) begin
      #1 b = busy;
      @(posedge clk);
      @(negedge clk);
      if (!b) begin
        words_acc++;
        return;
      end
      stall_cnt++;
    end
    chk("put_timeout", 1, 0);
  endtask

  task automatic send(input logic [5:0] len, input logic [1:0] dest, input int npay,
                      input logic [7:0] seed, input logic [7:0] par_flip,
                      input bit store, input logic [1:0] cause);
    logic [7:0] w, par;
    words_acc = 0;
    stall_cnt = 0;
    if (cause != 2'b00) err_q.push_back(cause);
    w   = {len, dest};
    par = w;
    if (store) exp_q[dest].push_back(w);
    put(w, 1'b1);
    for (int i = 0; i < npay; i++) begin
      w   = seed + 8'(i * 29);
      par = par ^ w;
      if (store) exp_q[dest].push_back(w);
      put(w, 1'b1);
    end
    w = par ^ par_flip;
    if (store) exp_q[dest].push_back(w);
    put(w, 1'b0);
    data_in = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
  endtask

  // Monitor: a pop decided at one negedge is checked at the next one.
  initial begin
    bit [2:0] pend, prev_vld;
    logic [7:0] e;
    read_enb = '0;
    pend     = '0;
    prev_vld = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pend     = '0;
        prev_vld = '0;
        read_enb = '0;
        continue;
      end
      for (int k = 0; k < 3; k++) begin
        if (pend[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_pop_p%0d", k), data_out[k*8 +: 8], 32'hFFFF);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("data_out_p%0d", k), data_out[k*8 +: 8], e);
          end
        end else if (prev_vld[k] && !vld_out[k]) begin
          chk($sformatf("flush_expected_p%0d", k), flush_drop[k] != 0, 1);
          chk($sformatf("flush_data_out_p%0d", k), data_out[k*8 +: 8], 0);
          for (int j = 0; j < flush_drop[k]; j++)
            if (exp_q[k].size() != 0) void'(exp_q[k].pop_front());
          flush_drop[k] = 0;
          flush_seen[k] = 1'b1;
        end
      end
      if (err) begin
        if (err_q.size() == 0) chk("unexpected_err", {30'd0, err_cause}, 32'hFF);
        else chk("err_cause", err_cause, err_q.pop_front());
      end
      read_enb = rd_mask;
      pend     = read_enb & vld_out;
      prev_vld = vld_out;
    end
  end

  initial begin
    resetn     = 1'b0;
    pkt_valid  = 1'b0;
    data_in    = '0;
    rd_mask    = '0;
    flush_seen = '0;
    for (int k = 0; k < 3; k++) flush_drop[k] = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cause", err_cause, 0);
    chk("rst_vld_out", vld_out, 0);
    chk("rst_data_out", data_out, 0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: normal packet to port 1 with a live reader
    rd_mask = 3'b010;
    send(6'd8, 2'd1, 8, 8'hA5, 8'h00, 1'b1, 2'b00);
    chk("t1_other_ports_idle", {vld_out[2], vld_out[0]}, 0);
    drain();

    // 2: FIFO fills, sender stalls, reads release it
    rd_mask = 3'b000;
    fork
      send(6'd20, 2'd2, 20, 8'h11, 8'h00, 1'b1, 2'b00);
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          #2;
          if (busy) begin
            seen = 1'b1;
            break;
          end
        end
        chk("t2_busy_on_full", seen, 1);
        chk("t2_words_before_full", words_acc, 16);
        repeat (4) @(negedge clk);
        #2 chk("t2_stall_holds", busy, 1);
        rd_mask = 3'b100;
      end
    join
    drain();

    // 3: parity error, words still stored
    rd_mask = 3'b001;
    send(6'd5, 2'd0, 5, 8'h3C, 8'h01, 1'b1, 2'b01);
    drain();

    // 4: length mismatch (header says 4, 3 sent)
    send(6'd4, 2'd0, 3, 8'h70, 8'h00, 1'b1, 2'b10);
    drain();

    // 5: bad destination 3, then a normal packet to port 1
    rd_mask = 3'b111;
    send(6'd2, 2'd3, 2, 8'h55, 8'h00, 1'b0, 2'b11);
    chk("t5_drop_no_stall", stall_cnt, 0);
    chk("t5_vld_out", vld_out, 0);
    send(6'd3, 2'd1, 3, 8'h9A, 8'h00, 1'b1, 2'b00);
    drain();

    // 6: unread packet times out; queued packet waits then loads
    rd_mask       = 3'b000;
    flush_seen    = '0;
    flush_drop[0] = 4;
    send(6'd2, 2'd0, 2, 8'h21, 8'h00, 1'b1, 2'b00);
    send(6'd3, 2'd0, 3, 8'h42, 8'h00, 1'b1, 2'b00);
    chk("t6_flush_seen", flush_seen[0], 1);
    chk("t6_wait_stall", stall_cnt >= 15, 1);
    rd_mask = 3'b001;
    drain();

    // 7: async reset mid-payload
    rd_mask = 3'b000;
    words_acc = 0;
    put({6'd6, 2'd2}, 1'b1);
    for (int i = 0; i < 3; i++) put(8'h30 + 8'(i), 1'b1);
    chk("t7_vld_before_reset", vld_out[2], 1);
    #3 resetn = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_err", err, 0);
    chk("t7_vld_out", vld_out, 0);
    chk("t7_data_out", data_out, 0);
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    err_q.delete();
    pkt_valid = 1'b0;
    data_in   = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rd_mask = 3'b010;
    send(6'd2, 2'd1, 2, 8'hC3, 8'h00, 1'b1, 2'b00);
    drain();

    repeat (5) @(negedge clk);
    chk("end_err_queue", err_q.size(), 0);
    chk("end_vld_out", vld_out, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
